// File: rtl/slice_row_sched.sv
// slice_row_sched: two-requester round-robin row writer into a ROWS x LANES
// byte array. The full array is presented on a valid/ready output once every
// row has been written.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_FILL | accepting row commands, out_valid low
//   ST_HOLD | full frame presented, all commands stalled until out_ready
module slice_row_sched #(
  parameter int ROWS   = 2,
  parameter int LANES  = 4,
  parameter int W      = 8,
  parameter int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [RIDX_W-1:0]       a_row,
  input  logic                    a_sel,
  input  logic [W-1:0]            a_d0,
  input  logic [W-1:0]            a_d1,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [RIDX_W-1:0]       b_row,
  input  logic                    b_sel,
  input  logic [W-1:0]            b_d0,
  input  logic [W-1:0]            b_d1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W*LANES*ROWS-1:0] dataout,
  output logic [7:0]              frame_cnt
);

  typedef enum logic {ST_FILL, ST_HOLD} state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;       // 0 = A has priority, 1 = B
  logic [ROWS-1:0]   filled_q, filled_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      data_q [ROWS][LANES];
  logic [W-1:0]      data_d [ROWS][LANES];

  logic              grant_a, grant_b;
  logic [RIDX_W-1:0] w_row;
  logic              w_sel;
  logic [W-1:0]      w_d0, w_d1;
  logic              w_in_range;

  // Arbitration: single write port, the pointer breaks ties and flips after each grant.
  always_comb begin
    grant_a = (state_q == ST_FILL) && a_valid && (!b_valid || !prio_q);
    grant_b = (state_q == ST_FILL) && b_valid && (!a_valid ||  prio_q);
    a_ready = grant_a && !rst;
    b_ready = grant_b && !rst;
  end

  // Next-state: row writes, filled tracking, frame handshake.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    filled_d    = filled_q;
    frame_cnt_d = frame_cnt_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    w_row       = grant_b ? b_row : a_row;
    w_sel       = grant_b ? b_sel : a_sel;
    w_d0        = grant_b ? b_d0  : a_d0;
    w_d1        = grant_b ? b_d1  : a_d1;
    w_in_range  = int'(w_row) < ROWS;

    if (grant_a || grant_b) begin
      prio_d = grant_a;
      // Out-of-range rows are consumed without touching storage.
      for (int r = 0; r < ROWS; r++) begin
        if (w_in_range && (w_row == RIDX_W'(r))) begin
          filled_d[r] = 1'b1;
          for (int l = 0; l < LANES; l++) begin
            if (w_sel && (l == LANES-1))      data_d[r][l] = w_d0;
            else if (w_sel && (l == LANES-2)) data_d[r][l] = w_d1;
            else                              data_d[r][l] = '0;
          end
        end
      end
      if (&filled_d) begin
        state_d     = ST_HOLD;
        out_valid_d = 1'b1;
      end
    end

    if ((state_q == ST_HOLD) && out_ready) begin
      state_d     = ST_FILL;
      out_valid_d = 1'b0;
      filled_d    = '0;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // State and storage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      prio_q      <= 1'b0;
      filled_q    <= '0;
      frame_cnt_q <= '0;
      out_valid_q <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int l = 0; l < LANES; l++)
          data_q[r][l] <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      filled_q    <= filled_d;
      frame_cnt_q <= frame_cnt_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
    end
  end

  // Flatten with data[0][0] in the MSBs.
  always_comb begin
    dataout = '0;
    for (int r = 0; r < ROWS; r++)
      for (int l = 0; l < LANES; l++)
        dataout[((ROWS-1-r)*LANES + (LANES-1-l))*W +: W] = data_q[r][l];
  end

  assign out_valid = out_valid_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_slice_row_sched.sv
// Directed bench for slice_row_sched with default parameters (2 rows x 4 lanes x 8 bits).
module tb_slice_row_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, a_sel;
  logic [0:0]  a_row;
  logic [7:0]  a_d0, a_d1;
  logic        b_valid, b_ready, b_sel;
  logic [0:0]  b_row;
  logic [7:0]  b_d0, b_d1;
  logic        out_valid, out_ready;
  logic [63:0] dataout;
  logic [7:0]  frame_cnt;

  int total = 0;
  int bad   = 0;
  logic [63:0] held;

  slice_row_sched dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_row(a_row), .a_sel(a_sel), .a_d0(a_d0), .a_d1(a_d1),
    .b_valid(b_valid), .b_ready(b_ready), .b_row(b_row), .b_sel(b_sel), .b_d0(b_d0), .b_d1(b_d1),
    .out_valid(out_valid), .out_ready(out_ready), .dataout(dataout), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic row, input logic sel, input logic [7:0] d0, input logic [7:0] d1);
    a_valid = v; a_row = row; a_sel = sel; a_d0 = d0; a_d1 = d1;
  endtask

  task automatic drive_b(input logic v, input logic row, input logic sel, input logic [7:0] d0, input logic [7:0] d1);
    b_valid = v; b_row = row; b_sel = sel; b_d0 = d0; b_d1 = d1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive_a(1'b1, 1'b0, 1'b1, 8'h11, 8'h22);
    drive_b(1'b0, 1'b1, 1'b1, 8'h33, 8'h44);
    #7;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    a_valid = 1'b0;
    #1 rst = 1'b0;

    // basic frame: A row 0, then B row 1
    tick();
    drive_a(1'b1, 1'b0, 1'b1, 8'h11, 8'h22);
    #1;
    chk("basic_a_ready", a_ready, 1);
    chk("basic_b_ready_idle", b_ready, 0);
    tick();
    a_valid = 1'b0;
    drive_b(1'b1, 1'b1, 1'b1, 8'h33, 8'h44);
    #1;
    chk("basic_ov_after_one", out_valid, 0);
    chk("basic_b_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    chk("basic_ov", out_valid, 1);
    chk("basic_dataout", dataout, 64'h0000_2211_0000_4433);
    chk("basic_frame_pre", frame_cnt, 0);

    // HOLD stall with A pending
    held = 64'h0000_2211_0000_4433;
    drive_a(1'b1, 1'b0, 1'b1, 8'h11, 8'h22);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_a_ready", a_ready, 0);
      chk("hold_dataout", dataout, held);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("exit_cycle_a_ready", a_ready, 0);
    chk("exit_cycle_ov", out_valid, 1);
    tick();
    out_ready = 1'b0;
    #1;
    chk("post_exit_ov", out_valid, 0);
    chk("post_exit_frame", frame_cnt, 1);
    chk("post_exit_a_ready", a_ready, 1);
    chk("post_exit_retained", dataout, held);
    tick();
    a_valid = 1'b0;

    // alternation after reset, consumer always ready
    do_reset();
    tick();
    drive_a(1'b1, 1'b0, 1'b1, 8'h12, 8'h34);
    drive_b(1'b1, 1'b1, 1'b1, 8'h56, 8'h78);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("alt_a_ready", a_ready, ((i % 3) == 0) ? 1 : 0);
      chk("alt_b_ready", b_ready, ((i % 3) == 1) ? 1 : 0);
      if ((i % 3) == 2) begin
        chk("alt_ov", out_valid, 1);
        chk("alt_dataout", dataout, 64'h0000_3412_0000_7856);
      end
      tick();
    end
    chk("alt_frames", frame_cnt, 3);
    chk("alt_ov_after", out_valid, 0);
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;

    // load, clear (rewrite) row 0, then load row 1
    drive_a(1'b1, 1'b0, 1'b1, 8'hFF, 8'hEE);
    #1 chk("clr_load_ready", a_ready, 1);
    tick();
    drive_a(1'b1, 1'b0, 1'b0, 8'hFF, 8'hEE);
    #1 chk("clr_clear_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    chk("clr_no_frame_on_rewrite", out_valid, 0);
    drive_b(1'b1, 1'b1, 1'b1, 8'h55, 8'h66);
    tick();
    b_valid = 1'b0;
    #1;
    chk("clr_ov", out_valid, 1);
    chk("clr_upper_zero", dataout[63:32], 0);
    chk("clr_lower", dataout[31:0], 32'h0000_6655);
    chk("clr_frame_pre", frame_cnt, 3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("clr_frame_post", frame_cnt, 4);
    tick();
    chk("clr_single_frame", out_valid, 0);

    // async reset in HOLD
    drive_a(1'b1, 1'b0, 1'b1, 8'h01, 8'h02);
    tick();
    a_valid = 1'b0;
    drive_b(1'b1, 1'b1, 1'b1, 8'h03, 8'h04);
    tick();
    b_valid = 1'b0;
    #1 chk("arst_hold_ov", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ov", out_valid, 0);
    chk("arst_dataout", dataout, 0);
    chk("arst_frame", frame_cnt, 0);
    rst = 1'b0;
    tick();
    drive_a(1'b1, 1'b1, 1'b1, 8'h07, 8'h08);
    #1 chk("arst_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    #1 chk("arst_one_write", out_valid, 0);
    drive_b(1'b1, 1'b0, 1'b1, 8'h09, 8'h0A);
    tick();
    b_valid = 1'b0;
    chk("arst_two_writes", out_valid, 1);
    chk("arst_data", dataout, 64'h0000_0A09_0000_0807);

    // 256 frames -> wrap
    do_reset();
    tick();
    drive_a(1'b1, 1'b0, 1'b1, 8'h21, 8'h43);
    drive_b(1'b1, 1'b1, 1'b1, 8'h65, 8'h87);
    out_ready = 1'b1;
    repeat (3*255) tick();
    chk("wrap_255", frame_cnt, 255);
    repeat (3) tick();
    chk("wrap_0", frame_cnt, 0);
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
